// File: rtl/tick_scheduler.sv
// tick_scheduler: programmable clock-enable generator.
// Emits a one-cycle tick every N cycles and a div_out that toggles on each
// tick. Divisor and burst length are loaded through a valid/ready handshake
// into shadow registers; runs are sequenced with start/stop in either
// free-running (count 0) or fixed-burst mode. All outputs come from flops.
module tick_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_count,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             div_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

  // Reload value for the period counter; a divisor of 0 behaves like 1.
  function automatic logic [WIDTH-1:0] reload_val(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    if (d == ZERO) begin
      r = ZERO;
    end else begin
      r = d - ONE;
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] sh_div_r, sh_div_s;
  logic [WIDTH-1:0] sh_cnt_r, sh_cnt_s;
  logic             pending_r, pending_s;
  logic             phase_r, phase_s;
  logic             done_r, done_s;

  logic             tick_s;
  logic             cfg_ready_s;
  logic             cfg_acc_s;

  // Output decode: everything below depends on registers only.
  always_comb begin
    tick_s      = (state_r == RUN) && (cnt_r == ZERO);
    cfg_ready_s = (state_r == IDLE) || !pending_r;
  end

  assign cfg_acc_s = cfg_valid & cfg_ready_s;

  // Next-state and datapath update for the IDLE/RUN sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rem_s     = rem_r;
    sh_div_s  = sh_div_r;
    sh_cnt_s  = sh_cnt_r;
    pending_s = pending_r;
    phase_s   = phase_r;
    done_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (cfg_acc_s) begin
          sh_div_s = cfg_div;
          sh_cnt_s = cfg_count;
        end else begin
          sh_div_s = sh_div_r;
        end
        if (start) begin
          // Bypass: a config accepted on the same edge is used immediately.
          state_s = RUN;
          cnt_s   = cfg_acc_s ? reload_val(cfg_div) : reload_val(sh_div_r);
          rem_s   = cfg_acc_s ? cfg_count : sh_cnt_r;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (tick_s) begin
          // Reload uses the shadow divisor, so changes land on a period boundary.
          cnt_s     = reload_val(sh_div_r);
          phase_s   = ~phase_r;
          pending_s = 1'b0;
          if (rem_r == ONE) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else if (rem_r != ZERO) begin
            rem_s = rem_r - ONE;
          end else begin
            rem_s = ZERO;
          end
        end else begin
          cnt_s = cnt_r - ONE;
        end
        if (cfg_acc_s) begin
          sh_div_s  = cfg_div;
          sh_cnt_s  = cfg_count;
          pending_s = 1'b1;
        end else begin
          sh_cnt_s = sh_cnt_r;
        end
        if (stop) begin
          // Abort: back to IDLE without done; shadows are kept.
          state_s   = IDLE;
          done_s    = 1'b0;
          pending_s = 1'b0;
        end else begin
          done_s = done_s;
        end
      end
      default: begin
        state_s   = IDLE;
        pending_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= ZERO;
      rem_r     <= ZERO;
      sh_div_r  <= ONE;
      sh_cnt_r  <= ZERO;
      pending_r <= 1'b0;
      phase_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      rem_r     <= rem_s;
      sh_div_r  <= sh_div_s;
      sh_cnt_r  <= sh_cnt_s;
      pending_r <= pending_s;
      phase_r   <= phase_s;
      done_r    <= done_s;
    end
  end

  assign tick      = tick_s;
  assign busy      = (state_r == RUN);
  assign cfg_ready = cfg_ready_s;
  assign div_out   = phase_r;
  assign done      = done_r;

endmodule
